// File: rtl/ahb_slave_arbiter_if.sv
// Signal bundle between the per-slave arbiter and the requesting masters / slave port.
// Handshake: hready is the single advance qualifier. Requests (hreq/hlock/htrans_m) are
// sampled, and every registered output moves, only on a rising edge where hready=1; with
// hready=0 the arbiter holds all outputs, so a wait-stated slave never sees a handover.
interface ahb_slave_arbiter_if #(
    parameter int MASTER_NUM = 4,
    parameter int ID_W       = $clog2(MASTER_NUM)
);
    logic [MASTER_NUM-1:0]   hreq;
    logic [MASTER_NUM-1:0]   hlock;
    logic [MASTER_NUM*2-1:0] htrans_m;
    logic                    hready;
    logic [MASTER_NUM-1:0]   grant;
    logic [MASTER_NUM-1:0]   data_sel;
    logic [ID_W-1:0]         master_id;
    logic                    grant_valid;
    logic                    hmastlock;
    logic [1:0]              arb_state;

    modport master (
        output hreq, hlock, htrans_m, hready,
        input  grant, data_sel, master_id, grant_valid, hmastlock, arb_state
    );

    modport slave (
        input  hreq, hlock, htrans_m, hready,
        output grant, data_sel, master_id, grant_valid, hmastlock, arb_state
    );
endinterface

// File: rtl/ahb_slave_arbiter.sv
// Per-slave AHB arbiter: holds ownership across bursts and locked sequences and
// hands over only at transfer boundaries, with a one-phase-delayed data-phase select.
module ahb_slave_arbiter #(
    parameter int MASTER_NUM = 4,
    parameter int ARB_MODE   = 0,
    parameter int ID_W       = $clog2(MASTER_NUM)
) (
    input logic              hclk,
    input logic              hreset_n,
    ahb_slave_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        NO_OWNER = 2'd0,
        OWNED    = 2'd1,
        LOCKED   = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [MASTER_NUM-1:0] grant_q, grant_d;
    logic [MASTER_NUM-1:0] data_sel_q, data_sel_d;
    logic [ID_W-1:0]       master_id_q, master_id_d;
    logic [ID_W-1:0]       last_id_q, last_id_d;
    logic                  hmastlock_q, hmastlock_d;

    logic                  owner_lock, owner_req, owner_idle, release_c;
    logic                  found;
    logic [ID_W-1:0]       winner;
    int                    idx;

    // The owner releases only on IDLE or a dropped request with no lock held;
    // BUSY/NONSEQ/SEQ keep the bus so a burst is never split.
    always_comb begin
        owner_lock = bus.hlock[master_id_q];
        owner_req  = bus.hreq[master_id_q];
        owner_idle = (bus.htrans_m[{master_id_q, 1'b0} +: 2] == 2'b00);
        release_c  = (state_q != NO_OWNER) && !owner_lock && (owner_idle || !owner_req);
    end

    // Scan in reverse so the last hit is the first in priority order.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        if (ARB_MODE == 1) begin
            for (int i = MASTER_NUM - 1; i >= 0; i--) begin
                if (bus.hreq[i]) begin
                    found  = 1'b1;
                    winner = ID_W'(i);
                end
            end
        end else begin
            for (int k = MASTER_NUM; k >= 1; k--) begin
                idx = int'(last_id_q) + k;
                if (idx >= MASTER_NUM) idx = idx - MASTER_NUM;
                if (bus.hreq[idx]) begin
                    found  = 1'b1;
                    winner = ID_W'(idx);
                end
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        data_sel_d  = data_sel_q;
        master_id_d = master_id_q;
        last_id_d   = last_id_q;
        hmastlock_d = hmastlock_q;
        if (bus.hready) begin
            data_sel_d = grant_q;
            if (state_q == NO_OWNER || release_c) begin
                grant_d = '0;
                if (found) begin
                    grant_d[winner] = 1'b1;
                    master_id_d     = winner;
                    last_id_d       = winner;
                    hmastlock_d     = bus.hlock[winner];
                    state_d         = bus.hlock[winner] ? LOCKED : OWNED;
                end else begin
                    master_id_d = '0;
                    hmastlock_d = 1'b0;
                    state_d     = NO_OWNER;
                end
            end else begin
                hmastlock_d = owner_lock;
                state_d     = owner_lock ? LOCKED : OWNED;
            end
        end
    end

    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            state_q     <= NO_OWNER;
            grant_q     <= '0;
            data_sel_q  <= '0;
            master_id_q <= '0;
            last_id_q   <= ID_W'(MASTER_NUM - 1);
            hmastlock_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            data_sel_q  <= data_sel_d;
            master_id_q <= master_id_d;
            last_id_q   <= last_id_d;
            hmastlock_q <= hmastlock_d;
        end
    end

    assign bus.grant       = grant_q;
    assign bus.data_sel    = data_sel_q;
    assign bus.master_id   = master_id_q;
    assign bus.grant_valid = |grant_q;
    assign bus.hmastlock   = hmastlock_q;
    assign bus.arb_state   = state_q;
endmodule

// File: tb/tb_ahb_slave_arbiter.sv
// Bench for ahb_slave_arbiter: vector table through a scoreboard queue on a
// round-robin instance, plus hand sequences for async reset and fixed priority.
module tb_ahb_slave_arbiter;
    logic hclk;
    logic hreset_n;

    ahb_slave_arbiter_if #(.MASTER_NUM(4)) rr_if ();
    ahb_slave_arbiter_if #(.MASTER_NUM(4)) fp_if ();

    ahb_slave_arbiter #(.MASTER_NUM(4), .ARB_MODE(0)) dut_rr (
        .hclk(hclk), .hreset_n(hreset_n), .bus(rr_if.slave)
    );
    ahb_slave_arbiter #(.MASTER_NUM(4), .ARB_MODE(1)) dut_fp (
        .hclk(hclk), .hreset_n(hreset_n), .bus(fp_if.slave)
    );

    // clock / reset
    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    initial begin
        #1000000;
        $display("FAIL watchdog: sim time limit reached, got no summary, need completion");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [3:0] hreq;
        logic [3:0] hlock;
        logic [7:0] htrans;
        logic       hready;
        logic [3:0] grant;
        logic [3:0] data_sel;
        logic [1:0] id;
        logic       lock;
    } vec_t;

    vec_t        vecs[$];
    logic [11:0] exp_q[$];
    int          n_cmp = 0;
    int          n_err = 0;

    // scoreboard: {grant, data_sel, master_id, hmastlock, grant_valid}
    function automatic logic [11:0] pack_exp(input vec_t v);
        return {v.grant, v.data_sel, v.id, v.lock, |v.grant};
    endfunction

    function automatic void compare(input string name, input logic [11:0] act, input logic [11:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got g=%b ds=%b id=%0d lk=%b gv=%b, need g=%b ds=%b id=%0d lk=%b gv=%b",
                     name, act[11:8], act[7:4], act[3:2], act[1], act[0],
                     exp[11:8], exp[7:4], exp[3:2], exp[1], exp[0]);
        end
    endfunction

    function automatic logic [11:0] rr_out();
        return {rr_if.grant, rr_if.data_sel, rr_if.master_id, rr_if.hmastlock, rr_if.grant_valid};
    endfunction

    function automatic logic [11:0] fp_out();
        return {fp_if.grant, fp_if.data_sel, fp_if.master_id, fp_if.hmastlock, fp_if.grant_valid};
    endfunction

    task automatic add(input logic [3:0] req, input logic [3:0] lk, input logic [7:0] tr,
                       input logic rdy, input logic [3:0] g, input logic [3:0] ds,
                       input logic [1:0] id, input logic ml);
        vec_t v;
        v.hreq = req; v.hlock = lk; v.htrans = tr; v.hready = rdy;
        v.grant = g; v.data_sel = ds; v.id = id; v.lock = ml;
        vecs.push_back(v);
    endtask

    // driver: called at posedge+1, drives, pushes expectation, checks after next edge
    task automatic step(input vec_t v, input bit fp, input string name);
        logic [11:0] e;
        if (fp) begin
            fp_if.hreq = v.hreq; fp_if.hlock = v.hlock; fp_if.htrans_m = v.htrans; fp_if.hready = v.hready;
        end else begin
            rr_if.hreq = v.hreq; rr_if.hlock = v.hlock; rr_if.htrans_m = v.htrans; rr_if.hready = v.hready;
        end
        exp_q.push_back(pack_exp(v));
        @(posedge hclk);
        #1;
        e = exp_q.pop_front();
        compare(name, fp ? fp_out() : rr_out(), e);
    endtask

    task automatic hstep(input logic [3:0] req, input logic [3:0] lk, input logic [7:0] tr,
                         input logic rdy, input logic [3:0] g, input logic [3:0] ds,
                         input logic [1:0] id, input logic ml, input bit fp, input string name);
        vec_t v;
        v.hreq = req; v.hlock = lk; v.htrans = tr; v.hready = rdy;
        v.grant = g; v.data_sel = ds; v.id = id; v.lock = ml;
        step(v, fp, name);
    endtask

    initial begin
        rr_if.hreq = '0; rr_if.hlock = '0; rr_if.htrans_m = '0; rr_if.hready = 1'b1;
        fp_if.hreq = '0; fp_if.hlock = '0; fp_if.htrans_m = '0; fp_if.hready = 1'b1;
        hreset_n = 1'b0;

        // idle, no requests
        for (int i = 0; i < 5; i++) add(4'h0, 4'h0, 8'h00, 1'b1, 4'h0, 4'h0, 2'd0, 1'b0);
        // round-robin rotation: NONSEQ then IDLE per owner
        add(4'hF, 4'h0, 8'hAA, 1'b1, 4'h1, 4'h0, 2'd0, 1'b0);
        add(4'hF, 4'h0, 8'h00, 1'b1, 4'h2, 4'h1, 2'd1, 1'b0);
        add(4'hF, 4'h0, 8'hAA, 1'b1, 4'h2, 4'h2, 2'd1, 1'b0);
        add(4'hF, 4'h0, 8'h00, 1'b1, 4'h4, 4'h2, 2'd2, 1'b0);
        add(4'hF, 4'h0, 8'hAA, 1'b1, 4'h4, 4'h4, 2'd2, 1'b0);
        add(4'hF, 4'h0, 8'h00, 1'b1, 4'h8, 4'h4, 2'd3, 1'b0);
        add(4'hF, 4'h0, 8'hAA, 1'b1, 4'h8, 4'h8, 2'd3, 1'b0);
        add(4'hF, 4'h0, 8'h00, 1'b1, 4'h1, 4'h8, 2'd0, 1'b0);
        add(4'hF, 4'h0, 8'hAA, 1'b1, 4'h1, 4'h1, 2'd0, 1'b0);
        add(4'hF, 4'h0, 8'h00, 1'b1, 4'h2, 4'h1, 2'd1, 1'b0);
        // master 1 INCR4 with master 0 requesting; wraps to master 0 on IDLE
        add(4'h3, 4'h0, 8'h08, 1'b1, 4'h2, 4'h2, 2'd1, 1'b0);
        for (int i = 0; i < 3; i++) add(4'h3, 4'h0, 8'h0C, 1'b1, 4'h2, 4'h2, 2'd1, 1'b0);
        add(4'h3, 4'h0, 8'h00, 1'b1, 4'h1, 4'h2, 2'd0, 1'b0);
        // wait states across a pending handover
        for (int i = 0; i < 3; i++) add(4'h6, 4'h0, 8'h00, 1'b0, 4'h1, 4'h2, 2'd0, 1'b0);
        add(4'h6, 4'h0, 8'h00, 1'b1, 4'h2, 4'h1, 2'd1, 1'b0);
        // master 2 wins while asserting hlock, holds through IDLE gaps
        add(4'h6, 4'h4, 8'h00, 1'b1, 4'h4, 4'h2, 2'd2, 1'b1);
        add(4'hF, 4'h4, 8'h20, 1'b1, 4'h4, 4'h4, 2'd2, 1'b1);
        add(4'hF, 4'h4, 8'h00, 1'b1, 4'h4, 4'h4, 2'd2, 1'b1);
        add(4'hF, 4'h4, 8'h20, 1'b1, 4'h4, 4'h4, 2'd2, 1'b1);
        add(4'hF, 4'h4, 8'h00, 1'b1, 4'h4, 4'h4, 2'd2, 1'b1);
        add(4'hF, 4'h0, 8'h00, 1'b1, 4'h8, 4'h4, 2'd3, 1'b0);
        add(4'hF, 4'h0, 8'hAA, 1'b1, 4'h8, 4'h8, 2'd3, 1'b0);

        repeat (2) @(posedge hclk);
        #1;
        compare("reset_rr", rr_out(), 12'h000);
        compare("reset_fp", fp_out(), 12'h000);
        hreset_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) step(vecs[i], 1'b0, $sformatf("vec%0d", i));

        // async reset in the middle of master 3's burst
        hstep(4'hF, 4'h0, 8'hFF, 1'b1, 4'h8, 4'h8, 2'd3, 1'b0, 1'b0, "burst_seq");
        #2 hreset_n = 1'b0;
        #1 compare("async_rst_now", rr_out(), 12'h000);
        @(posedge hclk);
        #1 compare("async_rst_held", rr_out(), 12'h000);
        hreset_n = 1'b1;
        hstep(4'h8, 4'h0, 8'h00, 1'b1, 4'h8, 4'h0, 2'd3, 1'b0, 1'b0, "post_rst_m3");

        // fixed priority instance
        hstep(4'hA, 4'h0, 8'h00, 1'b1, 4'h2, 4'h0, 2'd1, 1'b0, 1'b1, "fp_a0");
        hstep(4'hA, 4'h0, 8'h00, 1'b1, 4'h2, 4'h2, 2'd1, 1'b0, 1'b1, "fp_a1");
        hstep(4'hA, 4'h0, 8'hAA, 1'b1, 4'h2, 4'h2, 2'd1, 1'b0, 1'b1, "fp_hold");
        hstep(4'hB, 4'h0, 8'h00, 1'b1, 4'h1, 4'h2, 2'd0, 1'b0, 1'b1, "fp_m0");
        hstep(4'hA, 4'h0, 8'h00, 1'b1, 4'h2, 4'h1, 2'd1, 1'b0, 1'b1, "fp_back");
        hstep(4'hA, 4'h0, 8'h00, 1'b1, 4'h2, 4'h2, 2'd1, 1'b0, 1'b1, "fp_again");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/ahb_slave_arbiter.md
Name: ahb_slave_arbiter

Overview:
- Per-slave arbiter for the AHB interconnect. It decides which master owns one slave port.
- Produces two one-hot selects: `grant` for the address/control mux (master-to-slave payload) and `data_sel` for the data-phase mux. Both follow the one-hot select convention of the AHB channel muxes, where an all-zero select drives an all-zero (IDLE) payload.
- Ownership is held across bursts and locked sequences, and is handed over only at transfer boundaries.
- One instance per slave; the generator sets MASTER_NUM to the number of masters that can reach that slave.

Parameters:
- MASTER_NUM, 4, number of requesting masters (2..16).
- ARB_MODE, 0, 0 = round-robin, 1 = fixed priority (index 0 highest).
- ID_W, $clog2(MASTER_NUM), width of master_id.

Ports:
- hclk  input  1  system clock, all state updates on rising edge.
- hreset_n  input  1  asynchronous active-low reset.
- hreq  input  MASTER_NUM  per-master bus request to this slave.
- hlock  input  MASTER_NUM  per-master locked-transfer request.
- htrans_m  input  MASTER_NUM*2  per-master HTRANS, packed [i*2+:2]; IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- hready  input  1  slave HREADYOUT; 1 = current data phase completes this cycle.
- grant  output  MASTER_NUM  one-hot address-phase select; all-zero = no owner.
- data_sel  output  MASTER_NUM  one-hot data-phase select (grant delayed by one accepted address phase).
- master_id  output  ID_W  binary index of the grant bit (HMASTER).
- grant_valid  output  1  OR of grant.
- hmastlock  output  1  HMASTLOCK for the current address phase.

Behaviour:
- Reset (async assert, sync-to-hclk deassert handled upstream) clears everything immediately, including mid-burst:
  - grant, data_sel, master_id, grant_valid, hmastlock = 0.
  - Round-robin pointer last_id = MASTER_NUM-1, so master 0 has first priority.
- FSM states:
  - NO_OWNER: grant=0.
  - OWNED: a master holds the bus.
  - LOCKED: the owner has hlock=1.
- Updates happen only at a rising edge with hready=1. With hready=0, grant, data_sel, master_id, hmastlock and state all hold. A wait-stated slave never sees a handover.
- Release condition, evaluated in OWNED or LOCKED with hready=1:
  - hlock[owner]=0, and
  - either htrans_m[owner]=IDLE or hreq[owner]=0.
  - SEQ, BUSY or NONSEQ from the owner never release, so bursts are never split.
  - Masters must drive IDLE between bursts to yield.
- Arbitration point = NO_OWNER with hready=1, or the release condition true. At the arbitration point:
  - Winner is taken from hreq; the current owner is also eligible.
  - Round-robin: scan from (last_id+1) mod MASTER_NUM upward with wrap; first set bit wins.
  - Fixed priority: lowest set index wins.
  - If a winner exists: grant <= onehot(winner), master_id <= winner, last_id <= winner, hmastlock <= hlock[winner].
    - State becomes LOCKED if hlock[winner]=1, otherwise OWNED.
  - If hreq=0: grant <= 0, master_id <= 0, hmastlock <= 0, state NO_OWNER, last_id unchanged.
- LOCKED: ownership is kept regardless of other requests. hmastlock follows hlock[owner] each accepted cycle. On release, hlock=0 transitions to OWNED and then arbitrates normally the same edge.
- data_sel: on every edge with hready=1, data_sel <= grant. Otherwise it holds.
  - grant and data_sel may differ for one transfer during handover. This is the required AHB pipelined handover: new master in address phase, old master in data phase.
- grant is always zero or one-hot; data_sel likewise.
- grant_valid = |grant, combinational from the register.
- No combinational path from hreq/htrans_m to grant. Latency from request to grant is 1 cycle at an arbitration point.

Test Plan:
1. Reset then hreq=4'b0000, hready=1 for 5 cycles -> grant=0, data_sel=0, grant_valid=0, master_id=0 throughout.
2. Round-robin fairness: hreq=4'b1111; every owner drives NONSEQ then IDLE.
   - Grant sequence is 0001, 0010, 0100, 1000, 0001.
   - data_sel equals the previous grant one accepted cycle later.
3. Burst hold: master 1 granted and drives NONSEQ, SEQ×3 (INCR4); master 0 requests throughout.
   - grant stays 0010 until master 1 drives IDLE.
   - Next grant is 0100 if requested, else wraps to 0001.
4. Wait states: hready=0 for 3 cycles during an ownership change window.
   - grant, data_sel and master_id frozen.
   - Handover occurs on the first edge with hready=1.
5. Lock: master 2 asserts hlock with IDLE cycles between transfers; others request.
   - grant stays 0100 and hmastlock=1 until hlock drops.
   - Grant then moves to 1000 and hmastlock=0.
6. Async reset mid-burst (hreset_n low between edges) -> all outputs 0 immediately. After release with hreq=4'b1000, grant=1000 one edge later. ARB_MODE=1 with hreq=4'b1010 -> grant=0010 every arbitration.
